// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial test-pattern transmitter.
// The LFSR constants are only consumed when SEQ_PATTERN_GEN_PRBS_GAP_EN is defined.
package seq_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [6:0] LFSR_SEED = 7'h7F;
   // Polynomial x^7 + x^6 + 1: feedback from bits 6 and 5.
   localparam logic [6:0] LFSR_TAPS = 7'b110_0000;

endpackage

// File: rtl/seq_pattern_gen_lfsr7.sv
// 7-bit Fibonacci LFSR used for PRBS gap filling.
// Only compiled when SEQ_PATTERN_GEN_PRBS_GAP_EN is defined.
`ifdef SEQ_PATTERN_GEN_PRBS_GAP_EN
module lfsr7
   import seq_gen_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic adv,
   output logic bit_out
);

   logic [6:0] lfsr_q;
   logic [6:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (adv) begin
         lfsr_d = {lfsr_q[5:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign bit_out = lfsr_q[6];

endmodule
`endif

// File: rtl/seq_pattern_gen.sv
// Serial test-pattern transmitter: shifts a latched pattern out MSB-first, repeat_n times,
// with optional idle gaps. SEQ_PATTERN_GEN_PRBS_GAP_EN fills gaps with LFSR bits instead.
module seq_pattern_gen
   import seq_gen_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8,
   parameter int GAP_W = 4
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [GAP_W-1:0] gap_len,
   output logic             x,
   output logic             x_valid,
   output logic             last,
   output logic             busy,
   output logic             done
);

   localparam int IDX_W = $clog2(PAT_W);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   rep_q, rep_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [PAT_W-1:0]   pat_q, pat_d;
   logic [GAP_W-1:0]   gap_len_q, gap_len_d;
   logic               x_q, x_d;
   logic               x_valid_q, x_valid_d;
   logic               last_q, last_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

`ifdef SEQ_PATTERN_GEN_PRBS_GAP_EN
   logic prbs_bit;
   logic lfsr_adv;

   lfsr7 u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .adv     (lfsr_adv),
      .bit_out (prbs_bit)
   );
`endif

   // rep_q holds the number of repeats still to send, including the one in flight.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rep_d     = rep_q;
      gap_d     = gap_q;
      pat_d     = pat_q;
      gap_len_d = gap_len_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               pat_d     = pattern;
               gap_len_d = gap_len;
               rep_d     = repeat_n;
               idx_d     = IDX_MAX;
               state_d   = (repeat_n == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (idx_q == '0) begin
               if (rep_q > CNT_W'(1)) begin
                  rep_d = rep_q - CNT_W'(1);
                  if (gap_len_q == '0) begin
                     idx_d = IDX_MAX;
                  end else begin
                     state_d = GAP;
                     gap_d   = gap_len_q;
                  end
               end else begin
                  rep_d   = '0;
                  state_d = DONE;
               end
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         GAP: begin
            if (gap_q <= GAP_W'(1)) begin
               gap_d   = '0;
               idx_d   = IDX_MAX;
               state_d = SHIFT;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are derived from the next state so they line up with the state register.
   always_comb begin
      x_d       = 1'b0;
      x_valid_d = 1'b0;
      last_d    = 1'b0;
      busy_d    = (state_d == SHIFT) || (state_d == GAP);
      done_d    = (state_d == DONE);
`ifdef SEQ_PATTERN_GEN_PRBS_GAP_EN
      lfsr_adv  = 1'b0;
`endif
      if (state_d == SHIFT) begin
         x_d       = pat_d[idx_d];
         x_valid_d = 1'b1;
         last_d    = (idx_d == '0) && (rep_d == CNT_W'(1));
      end
`ifdef SEQ_PATTERN_GEN_PRBS_GAP_EN
      else if (state_d == GAP) begin
         x_d       = prbs_bit;
         x_valid_d = 1'b1;
         lfsr_adv  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         rep_q     <= '0;
         gap_q     <= '0;
         pat_q     <= '0;
         gap_len_q <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rep_q     <= rep_d;
         gap_q     <= gap_d;
         pat_q     <= pat_d;
         gap_len_q <= gap_len_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign last    = last_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Self-checking bench for seq_pattern_gen: table-driven single-shot vectors plus
// hand-written sequences for repeats, gaps, asynchronous reset and ignored start.
module tb_seq_pattern_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] pattern;
   logic [7:0] repeat_n;
   logic [3:0] gap_len;
   logic       x, x_valid, last, busy, done;

   int nChecks = 0;
   int nFails  = 0;

   typedef struct {
      logic       start;
      logic [3:0] pattern;
      logic [7:0] rep;
      logic [3:0] gap;
      logic       ex;
      logic       exv;
      logic       elast;
      logic       ebusy;
      logic       edone;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   seq_pattern_gen #(.PAT_W(4), .CNT_W(8), .GAP_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .pattern  (pattern),
      .repeat_n (repeat_n),
      .gap_len  (gap_len),
      .x        (x),
      .x_valid  (x_valid),
      .last     (last),
      .busy     (busy),
      .done     (done)
   );

   // Counts one comparison and reports it when it does not hold.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic ex, input logic exv,
                           input logic el, input logic eb, input logic ed);
      checkOutput({tag, ".x"},       {31'd0, x},       {31'd0, ex});
      checkOutput({tag, ".x_valid"}, {31'd0, x_valid}, {31'd0, exv});
      checkOutput({tag, ".last"},    {31'd0, last},    {31'd0, el});
      checkOutput({tag, ".busy"},    {31'd0, busy},    {31'd0, eb});
      checkOutput({tag, ".done"},    {31'd0, done},    {31'd0, ed});
   endtask

   // Drives inputs, then returns 1 time unit after the next rising edge.
   task automatic applyStimulus(input logic s, input logic [3:0] p,
                                input logic [7:0] r, input logic [3:0] g);
      start    = s;
      pattern  = p;
      repeat_n = r;
      gap_len  = g;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic vec_t mk(input logic s, input logic [3:0] p, input logic [7:0] r,
                               input logic [3:0] g, input logic ex, input logic exv,
                               input logic el, input logic eb, input logic ed);
      vec_t v;
      v.start = s; v.pattern = p; v.rep = r; v.gap = g;
      v.ex = ex; v.exv = exv; v.elast = el; v.ebusy = eb; v.edone = ed;
      return v;
   endfunction

   initial begin
      logic [11:0] stream2;
      logic [3:0]  hist;
      int          detCount;
      logic [10:0] expX3, expV3;
      logic        gapX, gapV;
      logic [3:0]  expBits5;

      reset    = 1'b1;
      start    = 1'b0;
      pattern  = 4'b0;
      repeat_n = 8'd0;
      gap_len  = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // Single 1010 frame; inputs change after acceptance and must not matter.
      vecs.push_back(mk(1'b1, 4'b1010, 8'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 4'b0101, 8'd3, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 4'b0101, 8'd3, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 4'b0101, 8'd3, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      // repeat_n == 0: immediate done, nothing sent.
      vecs.push_back(mk(1'b1, 4'b1111, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 4'b1111, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 4'b0000, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].start, vecs[i].pattern, vecs[i].rep, vecs[i].gap);
         checkAll($sformatf("vec%0d", i), vecs[i].ex, vecs[i].exv, vecs[i].elast,
                  vecs[i].ebusy, vecs[i].edone);
      end

      // Three back-to-back repeats with an overlapping 1010 detector.
      stream2  = 12'b1010_1010_1010;
      hist     = 4'b0;
      detCount = 0;
      applyStimulus(1'b1, 4'b1010, 8'd3, 4'd0);
      for (int k = 0; k < 12; k++) begin
         checkAll($sformatf("rep3.bit%0d", k), stream2[11-k], 1'b1, (k == 11), 1'b1, 1'b0);
         hist = {hist[2:0], x};
         if (k >= 3 && hist == 4'b1010) detCount++;
         applyStimulus(1'b0, 4'b0, 8'd0, 4'd0);
      end
      checkAll("rep3.done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rep3.detect_count", detCount, 32'd5);
      applyStimulus(1'b0, 4'b0, 8'd0, 4'd0);

      // Two repeats with a 3-cycle gap, starting from a freshly seeded LFSR.
      doReset();
`ifdef SEQ_PATTERN_GEN_PRBS_GAP_EN
      gapX = 1'b1;
      gapV = 1'b1;
`else
      gapX = 1'b0;
      gapV = 1'b0;
`endif
      expX3 = {4'b1010, gapX, gapX, gapX, 4'b1010};
      expV3 = {4'b1111, gapV, gapV, gapV, 4'b1111};
      applyStimulus(1'b1, 4'b1010, 8'd2, 4'd3);
      for (int k = 0; k < 11; k++) begin
         checkAll($sformatf("gap3.cyc%0d", k), expX3[10-k], expV3[10-k], (k == 10), 1'b1, 1'b0);
         applyStimulus(1'b0, 4'b0, 8'd0, 4'd0);
      end
      checkAll("gap3.done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0, 8'd0, 4'd0);

      // Asynchronous reset on the second bit of the first repeat.
      applyStimulus(1'b1, 4'b1100, 8'd2, 4'd0);
      checkAll("abort.bit0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'b0, 8'd0, 4'd0);
      checkAll("abort.bit1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      #3;
      reset = 1'b1;
      #1;
      checkAll("abort.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(1'b0, 4'b0, 8'd0, 4'd0);
      checkAll("abort.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Fresh start begins at the MSB; a start pulse mid-frame is ignored.
      expBits5 = 4'b0110;
      applyStimulus(1'b1, 4'b0110, 8'd1, 4'd0);
      for (int k = 0; k < 4; k++) begin
         checkAll($sformatf("restart.bit%0d", k), expBits5[3-k], 1'b1, (k == 3), 1'b1, 1'b0);
         if (k == 1) applyStimulus(1'b1, 4'b1111, 8'd5, 4'd2);
         else        applyStimulus(1'b0, 4'b0, 8'd0, 4'd0);
      end
      checkAll("restart.done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0, 8'd0, 4'd0);
      checkAll("restart.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
